// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - instruction fetch/decode sequencer driving the ALU/RegBank datapath controls
// Optional single-step control guarded by CTRL_SINGLE_STEP_EN.
module instr_fetch_decode #(
   parameter int ADDR_W            = 16,
   parameter int unsigned PC_RESET = 0
) (
   input  logic              clk,
   input  logic              rst,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_valid,
   output logic [15:0]       regEnable,
   output logic              flagEn,
   output logic              RorI,
   output logic [7:0]        opcode,
   output logic [3:0]        Rsrc,
   output logic [3:0]        Rdest,
   output logic [15:0]       imm,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [3:0]        rsrc_q, rsrc_d;
   logic [3:0]        rdest_q, rdest_d;
   logic [15:0]       imm_q, imm_d;
   logic              rori_q, rori_d;
   logic              mem_rd_q, mem_rd_d;
   logic              accept, avail, consume;
   logic              is_nop, is_cmp, do_exec;

`ifdef CTRL_SINGLE_STEP_EN
   logic step_q, pend_q, pend_d;

   // One remembered edge; it is consumed when a fetch request is launched.
   always_comb begin
      avail  = pend_q | (step & ~step_q);
      pend_d = avail & ~consume;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         step_q <= step;
         pend_q <= pend_d;
      end
   end
`else
   assign avail = 1'b1;
`endif

   assign accept = (state_q == FETCH) && mem_rd_q && mem_valid;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      opcode_d = opcode_q;
      rsrc_d   = rsrc_q;
      rdest_d  = rdest_q;
      imm_d    = imm_q;
      rori_d   = rori_q;
      mem_rd_d = 1'b0;
      consume  = 1'b0;
      case (state_q)
         FETCH: begin
            if (accept) begin
               ir_d    = mem_rdata;
               state_d = DECODE;
            end else if (mem_rd_q) begin
               mem_rd_d = 1'b1;
            end else begin
               mem_rd_d = avail;
               consume  = avail;
            end
         end
         DECODE: begin
            if (ir_q[15:12] == 4'hF) begin
               state_d = HALT;
            end else begin
               state_d = EXEC;
               rdest_d = ir_q[11:8];
               if (ir_q[15:12] == 4'h0) begin
                  opcode_d = {4'h0, ir_q[7:4]};
                  rori_d   = 1'b0;
                  rsrc_d   = ir_q[3:0];
               end else begin
                  opcode_d = {ir_q[15:12], 4'h0};
                  rori_d   = 1'b1;
                  rsrc_d   = 4'h0;
                  imm_d    = {{8{ir_q[7]}}, ir_q[7:0]};
               end
            end
         end
         EXEC: begin
            pc_d     = pc_q + 1'b1;
            state_d  = FETCH;
            // Request the next word immediately so zero-wait memory gives 3 cycles per instruction.
            mem_rd_d = avail;
            consume  = avail;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FETCH;
         pc_q     <= ADDR_W'(PC_RESET);
         ir_q     <= 16'h0000;
         opcode_q <= 8'h00;
         rsrc_q   <= 4'h0;
         rdest_q  <= 4'h0;
         imm_q    <= 16'h0000;
         rori_q   <= 1'b0;
         mem_rd_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         opcode_q <= opcode_d;
         rsrc_q   <= rsrc_d;
         rdest_q  <= rdest_d;
         imm_q    <= imm_d;
         rori_q   <= rori_d;
         mem_rd_q <= mem_rd_d;
      end
   end

   // Pulses decode from state so an async reset removes them in the same cycle.
   assign is_nop  = (ir_q == 16'h0000);
   assign is_cmp  = ((ir_q[15:12] == 4'h0) && (ir_q[7:4] == 4'hB)) || (ir_q[15:12] == 4'hB);
   assign do_exec = (state_q == EXEC) && !is_nop;

   assign regEnable = (do_exec && !is_cmp) ? (16'h0001 << rdest_q) : 16'h0000;
   assign flagEn    = do_exec;
   assign RorI      = rori_q;
   assign opcode    = opcode_q;
   assign Rsrc      = rsrc_q;
   assign Rdest     = rdest_q;
   assign imm       = imm_q;
   assign pc        = pc_q;
   assign mem_addr  = pc_q;
   assign mem_rd    = mem_rd_q;
   assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - directed self-checking bench for instr_fetch_decode
module tb_instr_fetch_decode;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] mem_addr, mem_rdata, regEnable, imm, pc;
   logic        mem_rd, mem_valid, flagEn, RorI, halted;
   logic [7:0]  opcode;
   logic [3:0]  Rsrc, Rdest;

   logic [3:0]  w_mem_addr, w_pc, w_Rsrc, w_Rdest;
   logic [15:0] w_regEnable, w_imm;
   logic        w_mem_rd, w_flagEn, w_RorI, w_halted, w_valid;
   logic [7:0]  w_opcode;
   logic [15:0] w_rdata = 16'h0352;
`ifdef CTRL_SINGLE_STEP_EN
   logic        step = 1'b0;
`endif

   logic [15:0] mem [0:15];
   int          wait_n = 0;
   int          rd_cnt;
   logic        force_valid = 1'b0;
   int          ntests = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   instr_fetch_decode u_dut (
      .clk(clk), .rst(rst),
`ifdef CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .regEnable(regEnable), .flagEn(flagEn), .RorI(RorI), .opcode(opcode),
      .Rsrc(Rsrc), .Rdest(Rdest), .imm(imm), .pc(pc), .halted(halted)
   );

   instr_fetch_decode #(.ADDR_W(4), .PC_RESET(15)) u_wrap (
      .clk(clk), .rst(rst),
`ifdef CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_rdata(w_rdata), .mem_valid(w_valid),
      .regEnable(w_regEnable), .flagEn(w_flagEn), .RorI(w_RorI), .opcode(w_opcode),
      .Rsrc(w_Rsrc), .Rdest(w_Rdest), .imm(w_imm), .pc(w_pc), .halted(w_halted)
   );

   // Memory with wait_n wait states; returns a HALT-looking word whenever data is not valid.
   always_comb begin
      mem_valid = force_valid | (mem_rd && (rd_cnt >= wait_n));
      mem_rdata = mem_valid ? mem[mem_addr[3:0]] : 16'hF0F0;
      w_valid   = w_mem_rd;
   end

   always @(posedge clk) begin
      if (rst || !mem_rd || mem_valid) rd_cnt <= 0;
      else rd_cnt <= rd_cnt + 1;
   end

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      ntests++; if (regEnable !== 16'h0 || flagEn !== 1'b0) begin nfail++; $display("FAIL reset_pulses: regEnable=%h flagEn=%b, want 0000/0", regEnable, flagEn); end
      ntests++; if ({RorI, opcode, Rsrc, Rdest, imm} !== 33'h0) begin nfail++; $display("FAIL reset_fields: RorI=%b op=%h Rsrc=%h Rdest=%h imm=%h, want all 0", RorI, opcode, Rsrc, Rdest, imm); end
      ntests++; if (mem_rd !== 1'b0 || halted !== 1'b0 || pc !== 16'h0) begin nfail++; $display("FAIL reset_ctrl: mem_rd=%b halted=%b pc=%h, want 0/0/0000", mem_rd, halted, pc); end
      ntests++; if (w_pc !== 4'hF) begin nfail++; $display("FAIL reset_pc_param: pc=%h, want f", w_pc); end
      rst = 1'b0;
      #1;
      ntests++; if (mem_rd !== 1'b0) begin nfail++; $display("FAIL reset_release_rd: mem_rd=%b, want 0", mem_rd); end
   endtask

   task automatic test_radd();
      @(negedge clk);
      ntests++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0) begin nfail++; $display("FAIL radd_fetch: mem_rd=%b addr=%h, want 1/0000", mem_rd, mem_addr); end
      @(negedge clk);
      ntests++; if (regEnable !== 16'h0 || flagEn !== 1'b0 || mem_rd !== 1'b0) begin nfail++; $display("FAIL radd_decode: regEnable=%h flagEn=%b mem_rd=%b, want 0000/0/0", regEnable, flagEn, mem_rd); end
      @(negedge clk);
      ntests++; if (opcode !== 8'h05 || Rsrc !== 4'h2 || Rdest !== 4'h3 || RorI !== 1'b0) begin nfail++; $display("FAIL radd_fields: op=%h Rsrc=%h Rdest=%h RorI=%b, want 05/2/3/0", opcode, Rsrc, Rdest, RorI); end
      ntests++; if (regEnable !== 16'h0008 || flagEn !== 1'b1 || pc !== 16'h0) begin nfail++; $display("FAIL radd_exec: regEnable=%h flagEn=%b pc=%h, want 0008/1/0000", regEnable, flagEn, pc); end
      @(negedge clk);
      ntests++; if (regEnable !== 16'h0 || flagEn !== 1'b0 || pc !== 16'h1 || mem_rd !== 1'b1) begin nfail++; $display("FAIL radd_after: regEnable=%h flagEn=%b pc=%h mem_rd=%b, want 0000/0/0001/1", regEnable, flagEn, pc, mem_rd); end
      ntests++; if (opcode !== 8'h05 || Rdest !== 4'h3) begin nfail++; $display("FAIL radd_stable: op=%h Rdest=%h, want 05/3", opcode, Rdest); end
   endtask

   task automatic test_imm_neg();
      @(negedge clk);
      @(negedge clk);
      ntests++; if (opcode !== 8'h50 || RorI !== 1'b1 || imm !== 16'hFFFE || Rsrc !== 4'h0 || Rdest !== 4'h4) begin nfail++; $display("FAIL imm_fields: op=%h RorI=%b imm=%h Rsrc=%h Rdest=%h, want 50/1/fffe/0/4", opcode, RorI, imm, Rsrc, Rdest); end
      ntests++; if (regEnable !== 16'h0010 || flagEn !== 1'b1) begin nfail++; $display("FAIL imm_exec: regEnable=%h flagEn=%b, want 0010/1", regEnable, flagEn); end
   endtask

   task automatic test_cmp_nop();
      repeat (3) @(negedge clk);
      ntests++; if (opcode !== 8'h0B || RorI !== 1'b0 || Rsrc !== 4'h1) begin nfail++; $display("FAIL cmp_fields: op=%h RorI=%b Rsrc=%h, want 0b/0/1", opcode, RorI, Rsrc); end
      ntests++; if (regEnable !== 16'h0 || flagEn !== 1'b1) begin nfail++; $display("FAIL cmp_exec: regEnable=%h flagEn=%b, want 0000/1", regEnable, flagEn); end
      repeat (3) @(negedge clk);
      ntests++; if (regEnable !== 16'h0 || flagEn !== 1'b0 || pc !== 16'h3) begin nfail++; $display("FAIL nop_exec: regEnable=%h flagEn=%b pc=%h, want 0000/0/0003", regEnable, flagEn, pc); end
      ntests++; if (opcode !== 8'h00 || imm !== 16'hFFFE) begin nfail++; $display("FAIL nop_fields: op=%h imm=%h, want 00/fffe", opcode, imm); end
   endtask

   task automatic test_wait_halt();
      wait_n = 4;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ntests++; if (mem_rd !== 1'b1 || halted !== 1'b0 || mem_addr !== 16'h4) begin nfail++; $display("FAIL wait_rd cycle %0d: mem_rd=%b halted=%b addr=%h, want 1/0/0004", i, mem_rd, halted, mem_addr); end
      end
      @(negedge clk);
      ntests++; if (mem_rd !== 1'b0 || halted !== 1'b0) begin nfail++; $display("FAIL wait_accept: mem_rd=%b halted=%b, want 0/0", mem_rd, halted); end
      @(negedge clk);
      wait_n = 0;
      ntests++; if (opcode !== 8'h02 || Rsrc !== 4'h3 || regEnable !== 16'h0002 || flagEn !== 1'b1) begin nfail++; $display("FAIL wait_exec: op=%h Rsrc=%h regEnable=%h flagEn=%b, want 02/3/0002/1", opcode, Rsrc, regEnable, flagEn); end
      repeat (3) @(negedge clk);
      ntests++; if (halted !== 1'b1 || pc !== 16'h5 || opcode !== 8'h02) begin nfail++; $display("FAIL halt_enter: halted=%b pc=%h op=%h, want 1/0005/02", halted, pc, opcode); end
      force_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ntests++; if (halted !== 1'b1 || mem_rd !== 1'b0 || regEnable !== 16'h0 || flagEn !== 1'b0 || pc !== 16'h5) begin nfail++; $display("FAIL halt_hold cycle %0d: halted=%b mem_rd=%b regEnable=%h flagEn=%b pc=%h", i, halted, mem_rd, regEnable, flagEn, pc); end
      end
      force_valid = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (3) @(negedge clk);
      ntests++; if (w_regEnable !== 16'h0008 || w_pc !== 4'hF || w_mem_addr !== 4'hF) begin nfail++; $display("FAIL wrap_exec: regEnable=%h pc=%h addr=%h, want 0008/f/f", w_regEnable, w_pc, w_mem_addr); end
      @(negedge clk);
      ntests++; if (w_pc !== 4'h0 || w_mem_addr !== 4'h0 || w_mem_rd !== 1'b1) begin nfail++; $display("FAIL wrap_pc: pc=%h addr=%h mem_rd=%b, want 0/0/1", w_pc, w_mem_addr, w_mem_rd); end
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      repeat (3) @(negedge clk);
      ntests++; if (regEnable !== 16'h0008) begin nfail++; $display("FAIL mid_pre: regEnable=%h, want 0008", regEnable); end
      #1 rst = 1'b1;
      #1;
      ntests++; if (regEnable !== 16'h0 || flagEn !== 1'b0 || mem_rd !== 1'b0 || pc !== 16'h0) begin nfail++; $display("FAIL mid_cancel: regEnable=%h flagEn=%b mem_rd=%b pc=%h, want 0000/0/0/0000", regEnable, flagEn, mem_rd, pc); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ntests++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0) begin nfail++; $display("FAIL mid_restart: mem_rd=%b addr=%h, want 1/0000", mem_rd, mem_addr); end
   endtask

   initial begin
      mem[0] = 16'h0352;
      mem[1] = 16'h54FE;
      mem[2] = 16'h02B1;
      mem[3] = 16'h0000;
      mem[4] = 16'h0123;
      mem[5] = 16'hF000;
      for (int i = 6; i < 16; i++) mem[i] = 16'hF000;
      test_reset();
      test_radd();
      test_imm_neg();
      test_cmp_nop();
      test_wait_halt();
      test_wrap();
      test_reset_mid_exec();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front-end sequencer that drives the datapath control interface: regEnable, flagEn, RorI, opcode, Rsrc, Rdest and imm.
- Fetches 16-bit instructions from a read-only instruction memory with a req/valid handshake, then decodes them.
- Issues one write-enable and flag-enable pulse per instruction.
- Replaces the hard-coded test FSM; its outputs connect one-to-one to the existing ALU/RegBank/mux datapath.

Parameters:
- ADDR_W, 16, width of program counter and mem_addr.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_addr  output  ADDR_W  instruction address (= pc).
- mem_rd  output  1  read request; high throughout FETCH until accepted.
- mem_rdata  input  16  instruction word; valid when mem_valid=1.
- mem_valid  input  1  read data valid; sampled only in FETCH.
- regEnable  output  16  one-hot register write enable; 1-cycle pulse in EXEC.
- flagEn  output  1  flag register update; 1-cycle pulse in EXEC.
- RorI  output  1  0 = Rsrc register operand, 1 = imm operand.
- opcode  output  8  ALU opcode.
- Rsrc  output  4  source register select.
- Rdest  output  4  destination register select.
- imm  output  16  sign-extended immediate.
- pc  output  ADDR_W  current program counter.
- halted  output  1  high in HALT state.

Behaviour:
- Reset (async, rst=1): state=FETCH; pc=PC_RESET; ir=0. Outputs: regEnable=0, flagEn=0, RorI=0, opcode=0, Rsrc=0, Rdest=0, imm=0, mem_rd=0, halted=0. mem_rd rises on the first clk edge after rst deasserts.
- Instruction fields: op=ir[15:12], Rdest=ir[11:8], ext=ir[7:4], Rsrc=ir[3:0], imm8=ir[7:0].
- Decode rules:
  - op=0x0: register form. opcode={4'h0,ext}, RorI=0, imm unchanged.
  - op=0x1..0xE: immediate form. opcode={op,4'h0}, RorI=1, imm={{8{imm8[7]}},imm8}, Rsrc=0.
  - op=0xF: HALT.
  - ir=16'h0000: NOP. Decodes normally but no pulses are issued.
  - Compare: ext=0xB in register form, or op=0xB in immediate form. flagEn pulses; regEnable stays 0.
  - All other non-NOP, non-HALT instructions: regEnable=1<<Rdest and flagEn=1 in EXEC.
- States:
  - FETCH: mem_rd=1, mem_addr=pc. When mem_valid=1, capture ir<=mem_rdata, drop mem_rd, go to DECODE. Otherwise stay; wait states are unbounded.
  - DECODE: register opcode, Rsrc, Rdest, imm and RorI from ir. Go to HALT if op=0xF, else EXEC.
  - EXEC: pulse regEnable/flagEn per the decode rules for exactly 1 cycle. pc<=pc+1, wrapping from 2^ADDR_W-1 to 0. Go to FETCH.
  - HALT: halted=1, mem_rd=0, no pulses, pc frozen. Exit only by reset.
- Timing:
  - opcode, Rsrc, Rdest, imm and RorI change only on the DECODE edge. They stay stable through EXEC and the following FETCH, so the combinational datapath settles before the enable pulse.
  - Zero-wait memory (mem_valid in the same cycle as mem_rd): 3 cycles per instruction, 1 regEnable pulse per 3 cycles. N wait states add N cycles.
- Handshake boundaries:
  - mem_valid outside FETCH is ignored.
  - mem_rdata is ignored when mem_valid=0.
- Reset mid-operation: any pending pulse is cancelled immediately (async). A request in flight is abandoned; mem_valid arriving after reset, during the first FETCH, is accepted as the response for address PC_RESET.
- Exclusivity: regEnable is always 0 or one-hot; never more than one bit set.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - FETCH does not assert mem_rd until a rising edge of step is detected; the edge is registered internally, so step held high counts once.
  - Exactly one instruction executes per step edge.
  - A step edge during DECODE or EXEC is remembered (1-deep) and consumed by the next FETCH.
- When undefined: no step port; FETCH requests immediately.

Test Plan:
- Reset: rst=1 mid-EXEC while regEnable=16'h0008 -> regEnable=0 that cycle; after release, mem_addr=0 and mem_rd=1.
- R-type ADD: mem[0]=16'h0352, zero-wait -> opcode=8'h05, Rsrc=2, Rdest=3, RorI=0; regEnable=16'h0008 and flagEn=1 for exactly 1 cycle in the 3rd cycle; pc=1.
- Immediate with negative value: mem[1]=16'h54FE -> opcode=8'h50, RorI=1, imm=16'hFFFE, regEnable=16'h0010.
- Compare and NOP: 16'h02B1 -> flagEn=1, regEnable=0. 16'h0000 -> no pulses, pc increments.
- Wait states and HALT: mem_valid delayed 4 cycles -> mem_rd held 5 cycles and ir captured only on valid. 16'hF000 -> halted=1, mem_rd stays 0 for 20 cycles, pc frozen.
- Wrap and step: ADDR_W=4, PC_RESET=15, one ADD -> pc=0 after EXEC. With CTRL_SINGLE_STEP_EN, step held high 10 cycles -> exactly 1 instruction executed.
